// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Shared constants and types for the MIPS-subset decode stage:
//   - opcode / funct encodings recognised by the decoder
//   - address-type and memory-size encodings carried on the flag outputs
//   - decoded_t: the bundle of fields produced for one instruction word
//   - small opcode-class helper functions
// ---------------------------------------------------------------------------
package decode_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_LWU   = 6'b100111;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes that need special handling
    localparam logic [5:0] FUNCT_JR   = 6'b001000;
    localparam logic [5:0] FUNCT_JALR = 6'b001001;

    // Branch/jump target addressing modes
    localparam logic [1:0] ADDR_TYPE_REG    = 2'b00;
    localparam logic [1:0] ADDR_TYPE_REGION = 2'b01;
    localparam logic [1:0] ADDR_TYPE_PCREL  = 2'b10;

    // Memory access sizes (equal to opcode[1:0] of loads/stores)
    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b11;

    // Link register written by JAL
    localparam logic [4:0] REG_RA = 5'd31;

    // Decoded fields of one instruction, before width extension
    typedef struct packed {
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wreg;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic        imm_zext;      // 1: zero-extend imm, 0: sign-extend
        logic [25:0] addr_offset;
        logic        pc_modify;
        logic        link_ret;
        logic [1:0]  addr_type;
        logic        equal;
        logic        inmediate;
        logic        mem_op;
        logic        mem_type;      // 0 load, 1 store
        logic [1:0]  mem_size;
        logic        unsign;
        logic        reg_write;
        logic        illegal;
    } decoded_t;

    // True for the supported load opcodes
    function automatic logic is_load_op(input logic [5:0] op);
        logic res;
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: res = 1'b1;
            default:                                     res = 1'b0;
        endcase
        return res;
    endfunction

    // True for the supported store opcodes
    function automatic logic is_store_op(input logic [5:0] op);
        logic res;
        case (op)
            OP_SB, OP_SH, OP_SW: res = 1'b1;
            default:             res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/decode_stage_pipe_fields.sv
// ---------------------------------------------------------------------------
// decode_fields
// Purely combinational decoder: one 32-bit MIPS-subset instruction word to a
// decoded_t bundle. Fields an instruction does not use are driven to 0.
// Ports:
//   instr    in  32         instruction word
//   dec      out decoded_t  decoded fields / flags
//   uses_rt  out 1          instruction reads rt as a source operand
// ---------------------------------------------------------------------------
module decode_fields
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output decoded_t    dec,
    output logic        uses_rt
);

    logic [5:0] opcode_s;
    logic [5:0] funct_s;

    assign opcode_s = instr[31:26];
    assign funct_s  = instr[5:0];

    // Opcode-class decode into the field bundle
    always_comb begin
        dec     = '0;
        uses_rt = 1'b0;
        casez (opcode_s)
            OP_RTYPE: begin
                dec.funct = funct_s;
                dec.rs    = instr[25:21];
                case (funct_s)
                    FUNCT_JR: begin
                        dec.pc_modify = 1'b1;
                        dec.addr_type = ADDR_TYPE_REG;
                    end
                    FUNCT_JALR: begin
                        // JALR is a register jump that also links
                        dec.pc_modify = 1'b1;
                        dec.addr_type = ADDR_TYPE_REG;
                        dec.wreg      = instr[15:11];
                        dec.link_ret  = 1'b1;
                        dec.reg_write = 1'b1;
                    end
                    default: begin
                        dec.rt        = instr[20:16];
                        dec.wreg      = instr[15:11];
                        dec.shamt     = instr[10:6];
                        dec.reg_write = 1'b1;
                        uses_rt       = 1'b1;
                    end
                endcase
            end
            OP_J, OP_JAL: begin
                dec.pc_modify   = 1'b1;
                dec.addr_type   = ADDR_TYPE_REGION;
                dec.addr_offset = instr[25:0];
                dec.link_ret    = (opcode_s == OP_JAL);
                dec.reg_write   = (opcode_s == OP_JAL);
                dec.wreg        = (opcode_s == OP_JAL) ? REG_RA : 5'd0;
            end
            OP_BEQ, OP_BNE: begin
                dec.rs          = instr[25:21];
                dec.rt          = instr[20:16];
                dec.imm         = instr[15:0];
                dec.addr_type   = ADDR_TYPE_PCREL;
                dec.addr_offset = {10'b0, instr[15:0]};
                dec.inmediate   = 1'b1;
                dec.equal       = (opcode_s == OP_BEQ);
                uses_rt         = 1'b1;
            end
            6'b001???: begin
                // Logical immediates (opcode[2]=1) are zero-extended
                dec.funct     = {3'b000, opcode_s[2:0]};
                dec.rs        = instr[25:21];
                dec.wreg      = instr[20:16];
                dec.imm       = instr[15:0];
                dec.imm_zext  = opcode_s[2];
                dec.inmediate = 1'b1;
                dec.reg_write = 1'b1;
            end
            default: begin
                if (is_load_op(opcode_s)) begin
                    dec.funct     = {3'b000, opcode_s[2:0]};
                    dec.rs        = instr[25:21];
                    dec.wreg      = instr[20:16];
                    dec.imm       = instr[15:0];
                    dec.mem_op    = 1'b1;
                    dec.mem_type  = 1'b0;
                    dec.mem_size  = opcode_s[1:0];
                    dec.unsign    = opcode_s[2];
                    dec.reg_write = 1'b1;
                end else if (is_store_op(opcode_s)) begin
                    dec.funct    = {3'b000, opcode_s[2:0]};
                    dec.rs       = instr[25:21];
                    dec.rt       = instr[20:16];
                    dec.imm      = instr[15:0];
                    dec.mem_op   = 1'b1;
                    dec.mem_type = 1'b1;
                    dec.mem_size = opcode_s[1:0];
                    uses_rt      = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// ---------------------------------------------------------------------------
// decode_stage_pipe
// Registered MIPS-subset decode stage: input FIFO (valid/ready), combinational
// decode of the FIFO head, and an ID/EX output register with its own
// valid/ready handshake. Inserts a one-cycle bubble on load-use hazards,
// supports flush and downstream backpressure.
// Ports:
//   i_clk, i_rst          clock (rising edge), async active-high reset
//   i_instr, i_pc         fetched instruction and its PC
//   i_valid / o_ready     input handshake (o_ready = FIFO not full)
//   i_flush               discard all buffered and registered instructions
//   i_ready / o_valid     output-register handshake
//   o_pc .. o_illegal     registered decoded fields of the output instruction
//   o_hazard_stall        a load-use bubble is being inserted this cycle
// ---------------------------------------------------------------------------
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int HAZARD_EN  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [31:0]       i_instr,
    input  logic [DATA_W-1:0] i_pc,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_flush,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_pc,
    output logic [5:0]        o_funct,
    output logic [4:0]        o_rs,
    output logic [4:0]        o_rt,
    output logic [4:0]        o_wreg,
    output logic [DATA_W-1:0] o_sa,
    output logic [DATA_W-1:0] o_imm_ext,
    output logic [25:0]       o_addr_offset,
    output logic              o_flg_pc_modify,
    output logic              o_flg_link_ret,
    output logic [1:0]        o_flg_addr_type,
    output logic              o_flg_equal,
    output logic              o_flg_inmediate,
    output logic              o_flg_mem_op,
    output logic              o_flg_mem_type,
    output logic [1:0]        o_flg_mem_size,
    output logic              o_flg_unsign,
    output logic              o_flg_reg_write,
    output logic              o_illegal,
    output logic              o_hazard_stall
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Storage plus pointers carrying one extra wrap bit for full/empty
    logic [31:0]       fifo_instr_r [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_pc_r    [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_r;
    logic [PTR_W:0]    rd_ptr_r;

    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic              advance_s;
    logic              hazard_s;
    logic [31:0]       head_instr_s;
    logic [DATA_W-1:0] head_pc_s;
    decoded_t          head_dec_s;
    logic              head_uses_rt_s;
    logic [DATA_W-1:0] head_imm_ext_s;
    logic [DATA_W-1:0] head_sa_s;

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                     (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);

    assign head_instr_s = fifo_instr_r[rd_ptr_r[PTR_W-1:0]];
    assign head_pc_s    = fifo_pc_r[rd_ptr_r[PTR_W-1:0]];

    decode_fields u_decode_fields (
        .instr   (head_instr_s),
        .dec     (head_dec_s),
        .uses_rt (head_uses_rt_s)
    );

    // Width extension of the head's shamt and immediate
    always_comb begin
        head_sa_s = {{(DATA_W-5){1'b0}}, head_dec_s.shamt};
        if (head_dec_s.imm_zext) begin
            head_imm_ext_s = {{(DATA_W-16){1'b0}}, head_dec_s.imm};
        end else begin
            head_imm_ext_s = {{(DATA_W-16){head_dec_s.imm[15]}}, head_dec_s.imm};
        end
    end

    // Load in the output register whose destination the head instruction reads
    always_comb begin
        hazard_s = 1'b0;
        if ((HAZARD_EN != 0) && o_valid && o_flg_mem_op && !o_flg_mem_type &&
            (o_wreg != 5'd0) && !empty_s) begin
            hazard_s = (o_wreg == head_dec_s.rs) ||
                       (head_uses_rt_s && (o_wreg == head_dec_s.rt));
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign advance_s      = !o_valid || i_ready;
    // o_ready is judged on the pre-edge fill level, so a same-cycle pop
    // never lets a push into a full FIFO
    assign o_ready        = !full_s && !i_rst;
    assign push_s         = i_valid && o_ready && !i_flush;
    assign pop_s          = advance_s && !empty_s && !hazard_s && !i_flush;
    assign o_hazard_stall = advance_s && hazard_s && !i_flush;

    // FIFO storage write (contents need no reset; pointers define validity)
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            fifo_instr_r[wr_ptr_r[PTR_W-1:0]] <= i_instr;
            fifo_pc_r[wr_ptr_r[PTR_W-1:0]]    <= i_pc;
        end
    end

    // FIFO pointer update; flush empties the queue and drops any push
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (i_flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    // ID/EX output register: flush > advance (load or bubble) > hold
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid         <= 1'b0;
            o_pc            <= '0;
            o_funct         <= 6'd0;
            o_rs            <= 5'd0;
            o_rt            <= 5'd0;
            o_wreg          <= 5'd0;
            o_sa            <= '0;
            o_imm_ext       <= '0;
            o_addr_offset   <= 26'd0;
            o_flg_pc_modify <= 1'b0;
            o_flg_link_ret  <= 1'b0;
            o_flg_addr_type <= 2'b00;
            o_flg_equal     <= 1'b0;
            o_flg_inmediate <= 1'b0;
            o_flg_mem_op    <= 1'b0;
            o_flg_mem_type  <= 1'b0;
            o_flg_mem_size  <= 2'b00;
            o_flg_unsign    <= 1'b0;
            o_flg_reg_write <= 1'b0;
            o_illegal       <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (advance_s) begin
            if (pop_s) begin
                o_valid         <= 1'b1;
                o_pc            <= head_pc_s;
                o_funct         <= head_dec_s.funct;
                o_rs            <= head_dec_s.rs;
                o_rt            <= head_dec_s.rt;
                o_wreg          <= head_dec_s.wreg;
                o_sa            <= head_sa_s;
                o_imm_ext       <= head_imm_ext_s;
                o_addr_offset   <= head_dec_s.addr_offset;
                o_flg_pc_modify <= head_dec_s.pc_modify;
                o_flg_link_ret  <= head_dec_s.link_ret;
                o_flg_addr_type <= head_dec_s.addr_type;
                o_flg_equal     <= head_dec_s.equal;
                o_flg_inmediate <= head_dec_s.inmediate;
                o_flg_mem_op    <= head_dec_s.mem_op;
                o_flg_mem_type  <= head_dec_s.mem_type;
                o_flg_mem_size  <= head_dec_s.mem_size;
                o_flg_unsign    <= head_dec_s.unsign;
                o_flg_reg_write <= head_dec_s.reg_write;
                o_illegal       <= head_dec_s.illegal;
            end else begin
                // Empty FIFO or load-use bubble
                o_valid <= 1'b0;
            end
        end else begin
            o_valid <= o_valid;
        end
    end

endmodule
